// File: rtl/neuron_layer_wta_ctrl_pkg.sv
// Shared types and helpers for the winner-take-all neuron layer controller.
package neuron_layer_wta_ctrl_pkg;
  localparam int DWIDTH = 20;

  typedef enum logic [2:0] {IDLE, SETTLE, SCAN, FIRE, UPDATE} state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/neuron_layer_wta_ctrl_if.sv
// Neuron-array, config and spike handshake bundle for the WTA controller.
interface neuron_layer_wta_ctrl_if
  import neuron_layer_wta_ctrl_pkg::*;
#(
  parameter int p_neurons = 4,
  parameter int p_dwidth  = DWIDTH
);
  logic [10:1]                          evt;
  logic [p_neurons-1:0][p_dwidth-1:0]   sum;
  logic [p_neurons-1:0][p_dwidth-1:0]   threshold;
  logic                                 learn_en;
  logic                                 cfg_we;
  logic [idx_w(p_neurons)-1:0]          cfg_addr;
  logic [p_dwidth-1:0]                  cfg_data;
  logic                                 spike_valid;
  logic                                 spike_ready;
  logic [idx_w(p_neurons)-1:0]          spike_id;
  logic [p_dwidth-1:0]                  spike_val;
  logic                                 busy;
  logic [7:0]                           drop_cnt;

  modport slave (
    input  evt, sum, learn_en, cfg_we, cfg_addr, cfg_data, spike_ready,
    output threshold, spike_valid, spike_id, spike_val, busy, drop_cnt
  );
  modport master (
    output evt, sum, learn_en, cfg_we, cfg_addr, cfg_data, spike_ready,
    input  threshold, spike_valid, spike_id, spike_val, busy, drop_cnt
  );
endinterface

// File: rtl/neuron_layer_wta_ctrl_wta_max_scan.sv
// Serial max tracker: keeps the largest sum that strictly beats its threshold.
module wta_max_scan
  import neuron_layer_wta_ctrl_pkg::*;
#(
  parameter int p_neurons = 4,
  parameter int p_dwidth  = DWIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          en,
  input  logic [idx_w(p_neurons)-1:0]   idx,
  input  logic [p_dwidth-1:0]           sum,
  input  logic [p_dwidth-1:0]           thr,
  output logic                          found,
  output logic [idx_w(p_neurons)-1:0]   win_idx,
  output logic [p_dwidth-1:0]           win_val,
  output logic                          nxt_found,
  output logic [idx_w(p_neurons)-1:0]   nxt_idx,
  output logic [p_dwidth-1:0]           nxt_val
);
  logic take;

  // Strict greater-than on the running max keeps ties with the lower index.
  always_comb begin
    take      = en && (sum > thr) && (!found || (sum > win_val));
    nxt_found = found | take;
    nxt_idx   = take ? idx : win_idx;
    nxt_val   = take ? sum : win_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found   <= 1'b0;
      win_idx <= '0;
      win_val <= '0;
    end else if (clear) begin
      found   <= 1'b0;
      win_idx <= '0;
      win_val <= '0;
    end else if (en) begin
      found   <= nxt_found;
      win_idx <= nxt_idx;
      win_val <= nxt_val;
    end
  end
endmodule

// File: rtl/neuron_layer_wta_ctrl.sv
// Layer sequencer: settle, serial WTA scan, spike handshake, threshold adaptation.
module neuron_layer_wta_ctrl
  import neuron_layer_wta_ctrl_pkg::*;
#(
  parameter int p_neurons   = 4,
  parameter int p_dwidth    = DWIDTH,
  parameter int p_settle    = 2,
  parameter int p_eta_shift = 3,
  parameter int p_thr_init  = 256,
  parameter int p_thr_min   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  neuron_layer_wta_ctrl_if.slave  bus
);
  localparam int IW   = idx_w(p_neurons);
  localparam int CMAX = (p_settle > p_neurons) ? p_settle : p_neurons;
  localparam int CW   = idx_w(CMAX);

  state_e                             state;
  logic [CW-1:0]                      cnt;
  logic [p_neurons-1:0][p_dwidth-1:0] thr, thr_dec;
  logic                               spike_valid;
  logic [IW-1:0]                      spike_id;
  logic [p_dwidth-1:0]                spike_val;
  logic [7:0]                         drop_cnt;

  logic                scan_en, scan_last, found, nxt_found;
  logic [IW-1:0]       scan_idx, win_idx, nxt_idx;
  logic [p_dwidth-1:0] win_val, nxt_val, step_up;

  assign scan_en   = (state == SCAN);
  assign scan_idx  = cnt[IW-1:0];
  assign scan_last = scan_en && (cnt == CW'(p_neurons - 1));

  wta_max_scan #(.p_neurons(p_neurons), .p_dwidth(p_dwidth)) u_scan (
    .clk(clk), .rst_n(rst_n), .clear(state == SETTLE), .en(scan_en),
    .idx(scan_idx), .sum(bus.sum[scan_idx]), .thr(thr[scan_idx]),
    .found(found), .win_idx(win_idx), .win_val(win_val),
    .nxt_found(nxt_found), .nxt_idx(nxt_idx), .nxt_val(nxt_val)
  );

  // Winner moves toward its sum; with no winner every threshold decays to a floor.
  assign step_up = (win_val - thr[win_idx]) >> p_eta_shift;
  always_comb begin
    thr_dec = thr;
    for (int k = 0; k < p_neurons; k++) begin
      thr_dec[k] = thr[k] - (thr[k] >> p_eta_shift);
      if (thr_dec[k] < p_dwidth'(p_thr_min)) thr_dec[k] = p_dwidth'(p_thr_min);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      for (int k = 0; k < p_neurons; k++) thr[k] <= p_dwidth'(p_thr_init);
      spike_valid <= 1'b0;
      spike_id    <= '0;
      spike_val   <= '0;
      drop_cnt    <= '0;
    end else begin
      if ((|bus.evt) && (state != IDLE) && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (bus.cfg_we && (int'(bus.cfg_addr) < p_neurons)) thr[bus.cfg_addr] <= bus.cfg_data;
          if (|bus.evt) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        SETTLE: begin
          if (cnt == CW'(p_settle - 1)) begin
            state <= SCAN;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        SCAN: begin
          if (scan_last) begin
            if (nxt_found) begin
              state       <= FIRE;
              spike_valid <= 1'b1;
              spike_id    <= nxt_idx;
              spike_val   <= nxt_val;
            end else state <= UPDATE;
          end else cnt <= cnt + CW'(1);
        end
        FIRE: begin
          if (bus.spike_ready) begin
            spike_valid <= 1'b0;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          if (bus.learn_en) begin
            if (found) thr[win_idx] <= thr[win_idx] + step_up;
            else       thr <= thr_dec;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.threshold   = thr;
  assign bus.spike_valid = spike_valid;
  assign bus.spike_id    = spike_id;
  assign bus.spike_val   = spike_val;
  assign bus.busy        = (state != IDLE);
  assign bus.drop_cnt    = drop_cnt;
endmodule

// File: tb/tb_neuron_layer_wta_ctrl.sv
// Directed bench for the WTA layer controller with hand-computed expectations.
module tb_neuron_layer_wta_ctrl;
  import neuron_layer_wta_ctrl_pkg::*;
  localparam int N  = 4;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_layer_wta_ctrl_if #(.p_neurons(N), .p_dwidth(DW)) bus ();

  neuron_layer_wta_ctrl #(
    .p_neurons(N), .p_dwidth(DW), .p_settle(2), .p_eta_shift(3),
    .p_thr_init(256), .p_thr_min(16)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sums(input int s0, input int s1, input int s2, input int s3);
    bus.sum[0] = DW'(s0);
    bus.sum[1] = DW'(s1);
    bus.sum[2] = DW'(s2);
    bus.sum[3] = DW'(s3);
  endtask

  task automatic cfg(input int a, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'(a);
    bus.cfg_data = DW'(d);
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic check_thr(input string tag, input int k, input int v);
    check(tag, 64'(bus.threshold[k]), 64'(v));
  endtask

  // One event pulse, then accept any spike and wait (bounded) for IDLE.
  task automatic run_event();
    int n;
    bus.evt = 10'b0000000001;
    step();
    bus.evt = '0;
    bus.spike_ready = 1'b1;
    n = 0;
    while (bus.busy && n < 60) begin
      step();
      n++;
    end
    check("idle_wait", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n;
    bus.evt = '0; bus.learn_en = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.spike_ready = 1'b0;
    set_sums(0, 0, 0, 0);

    // Reset state
    #12;
    for (int k = 0; k < N; k++) check_thr("rst_thr", k, 256);
    check("rst_valid", 64'(bus.spike_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_drop", 64'(bus.drop_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic winner with tie and latency
    set_sums(300, 500, 200, 500);
    bus.spike_ready = 1'b0;
    bus.evt = 10'b0000000100;
    step();
    bus.evt = '0;
    repeat (5) step();
    check("lat_early", 64'(bus.spike_valid), 64'd0);
    step();
    check("lat_valid", 64'(bus.spike_valid), 64'd1);
    check("win_id", 64'(bus.spike_id), 64'd1);
    check("win_val", 64'(bus.spike_val), 64'd500);
    bus.spike_ready = 1'b1;
    step();
    check("hs_drop", 64'(bus.spike_valid), 64'd0);
    step();
    check("upd_idle", 64'(bus.busy), 64'd0);
    check_thr("learn_thr1", 1, 286);
    check_thr("learn_thr0", 0, 256);

    // No winner: decay toward the floor
    cfg(1, 256);
    set_sums(256, 100, 0, 256);
    run_event();
    for (int k = 0; k < N; k++) check_thr("decay1", k, 224);
    set_sums(0, 0, 0, 0);
    run_event();
    check_thr("decay2", 0, 196);
    repeat (28) run_event();
    for (int k = 0; k < N; k++) check_thr("floor", k, 16);

    // FIRE hold with drops and drop saturation
    for (int k = 0; k < N; k++) cfg(k, 256);
    set_sums(300, 0, 0, 0);
    bus.spike_ready = 1'b0;
    bus.evt = 10'b0000000010;
    step();
    bus.evt = '0;
    n = 0;
    while (!bus.spike_valid && n < 40) begin
      step();
      n++;
    end
    check("fire_valid", 64'(bus.spike_valid), 64'd1);
    bus.evt = 10'h3FF;
    for (int i = 0; i < 20; i++) begin
      step();
      check("fire_hold", 64'({bus.spike_valid, bus.spike_id, bus.spike_val}),
            64'({1'b1, 2'd0, 20'd300}));
    end
    check("drop20", 64'(bus.drop_cnt), 64'd20);
    repeat (280) step();
    check("drop_sat", 64'(bus.drop_cnt), 64'd255);
    check("fire_busy", 64'(bus.busy), 64'd1);
    bus.evt = '0;
    bus.spike_ready = 1'b1;
    step();
    step();
    check("fire_idle", 64'(bus.busy), 64'd0);
    check_thr("learn_thr0b", 0, 261);

    // Cfg write with event applies; cfg write during scan ignored
    set_sums(0, 0, 50, 0);
    bus.spike_ready = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_data = DW'(10);
    bus.evt = 10'b0000000001;
    step();
    bus.cfg_we = 1'b0;
    bus.evt = '0;
    check_thr("cfg_evt", 2, 10);
    step();
    step();
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_data = DW'(100);
    step();
    bus.cfg_we = 1'b0;
    check_thr("cfg_scan_ign", 2, 10);
    step(); step(); step();
    check("cfg_valid", 64'(bus.spike_valid), 64'd1);
    check("cfg_id", 64'(bus.spike_id), 64'd2);
    check("cfg_val", 64'(bus.spike_val), 64'd50);
    bus.spike_ready = 1'b1;
    step();
    step();
    check("cfg_idle", 64'(bus.busy), 64'd0);
    check_thr("cfg_learn", 2, 15);

    // Reset during scan, then a clean event
    set_sums(300, 0, 0, 0);
    bus.spike_ready = 1'b0;
    bus.evt = 10'b0000000001;
    step();
    bus.evt = '0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) check_thr("mid_rst_thr", k, 256);
    check("mid_rst_valid", 64'(bus.spike_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_drop", 64'(bus.drop_cnt), 64'd0);
    check("mid_rst_val", 64'(bus.spike_val), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    set_sums(0, 400, 0, 0);
    bus.evt = 10'b1000000000;
    step();
    bus.evt = '0;
    repeat (5) step();
    check("post_early", 64'(bus.spike_valid), 64'd0);
    step();
    check("post_valid", 64'(bus.spike_valid), 64'd1);
    check("post_id", 64'(bus.spike_id), 64'd1);
    check("post_val", 64'(bus.spike_val), 64'd400);
    bus.spike_ready = 1'b1;
    step();
    step();
    check("post_idle", 64'(bus.busy), 64'd0);
    check_thr("post_learn", 1, 274);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
